// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the five-stage MIPS core.
// Contents: hazard FSM state encoding, NOP instruction word, the
// hard-wired zero register number.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        FLUSH  = 2'd2,
        FREEZE = 2'd3
    } hz_state_e;

    localparam logic [31:0] NOP      = 32'h0;
    localparam logic [4:0]  REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX hazard sources and data-memory
// wait in, pipeline register enables / flush / bubble and debug
// counters out.
// Modports: master = pipeline side driving hazard sources,
//           slave  = hazard_ctrl.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       rs_ID;
    logic [4:0]       rt_ID;
    logic             usesRs_ID;
    logic             usesRt_ID;
    logic             MemRead_EX;
    logic [4:0]       rt_EX;
    logic             branchTaken_EX;
    logic             Jump_EX;
    logic             memBusy;
    logic             pcWrite;
    logic             ifidWrite;
    logic             ifidFlush;
    logic             idexWrite;
    logic             idexBubble;
    logic             exmemWrite;
    logic [1:0]       state;
    logic [CNT_W-1:0] stallCycles;
    logic [CNT_W-1:0] flushCount;

    modport master (
        output rs_ID, rt_ID, usesRs_ID, usesRt_ID, MemRead_EX, rt_EX,
               branchTaken_EX, Jump_EX, memBusy,
        input  pcWrite, ifidWrite, ifidFlush, idexWrite, idexBubble,
               exmemWrite, state, stallCycles, flushCount
    );

    modport slave (
        input  rs_ID, rt_ID, usesRs_ID, usesRt_ID, MemRead_EX, rt_EX,
               branchTaken_EX, Jump_EX, memBusy,
        output pcWrite, ifidWrite, ifidFlush, idexWrite, idexBubble,
               exmemWrite, state, stallCycles, flushCount
    );
endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use hazard equation between ID and EX.
// Ports: rs_ID/rt_ID + usesRs_ID/usesRt_ID (ID sources),
//        MemRead_EX/rt_EX (load in EX), hazard (out).
module load_use_detect
    import pipe_pkg::*;
(
    input  logic [4:0] rs_ID,
    input  logic [4:0] rt_ID,
    input  logic       usesRs_ID,
    input  logic       usesRt_ID,
    input  logic       MemRead_EX,
    input  logic [4:0] rt_EX,
    output logic       hazard
);
    // A load to $zero writes nothing, so it can never be a producer.
    assign hazard = MemRead_EX && (rt_EX != REG_ZERO) &&
                    ((usesRs_ID && (rs_ID == rt_EX)) ||
                     (usesRt_ID && (rt_ID == rt_EX)));
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, EX redirect flushes,
// data-memory freeze, plus saturating stall/flush debug counters.
// Ports: clk, reset (sync, active-high), bus (hazard_ctrl_if.slave).
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned LOAD_LATENCY = 1,
    parameter int unsigned CNT_W        = 16
)(
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  bus
);
    hz_state_e        state_q, state_d, saved_q, saved_d, eff;
    logic [2:0]       rem_q, rem_d;
    logic [CNT_W-1:0] stall_q, flush_q;
    logic             hazard, redirect;
    logic             pc_w, ifid_w, ifid_f, idex_w, idex_b, exmem_w;
    logic             flush_inc;

    load_use_detect u_lud (
        .rs_ID      (bus.rs_ID),
        .rt_ID      (bus.rt_ID),
        .usesRs_ID  (bus.usesRs_ID),
        .usesRt_ID  (bus.usesRt_ID),
        .MemRead_EX (bus.MemRead_EX),
        .rt_EX      (bus.rt_EX),
        .hazard     (hazard)
    );

    assign redirect = bus.branchTaken_EX || bus.Jump_EX;

    always_comb begin
        // FREEZE resumes the state it interrupted; FLUSH is unused and acts as RUN.
        eff = (state_q == FREEZE) ? saved_q : state_q;
        if (eff == FLUSH) eff = RUN;

        pc_w      = 1'b1;
        ifid_w    = 1'b1;
        ifid_f    = 1'b0;
        idex_w    = 1'b1;
        idex_b    = 1'b0;
        exmem_w   = 1'b1;
        state_d   = eff;
        saved_d   = saved_q;
        rem_d     = rem_q;
        flush_inc = 1'b0;

        if (bus.memBusy) begin
            pc_w    = 1'b0;
            ifid_w  = 1'b0;
            idex_w  = 1'b0;
            exmem_w = 1'b0;
            state_d = FREEZE;
            saved_d = eff;
        end else if (redirect) begin
            ifid_f    = 1'b1;
            idex_b    = 1'b1;
            state_d   = RUN;
            rem_d     = '0;
            flush_inc = 1'b1;
        end else if (eff == LSTALL) begin
            pc_w    = 1'b0;
            ifid_w  = 1'b0;
            idex_b  = 1'b1;
            rem_d   = rem_q - 3'd1;
            state_d = (rem_d == '0) ? RUN : LSTALL;
        end else if (hazard) begin
            pc_w    = 1'b0;
            ifid_w  = 1'b0;
            idex_b  = 1'b1;
            rem_d   = 3'(LOAD_LATENCY - 1);
            state_d = (LOAD_LATENCY > 1) ? LSTALL : RUN;
        end

        if (reset) begin
            pc_w      = 1'b0;
            ifid_w    = 1'b0;
            ifid_f    = 1'b1;
            idex_w    = 1'b0;
            idex_b    = 1'b1;
            exmem_w   = 1'b0;
            flush_inc = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            saved_q <= RUN;
            rem_q   <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            rem_q   <= rem_d;
            if (!pc_w && (stall_q != '1))
                stall_q <= stall_q + CNT_W'(1);
            if (flush_inc && (flush_q != '1))
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign bus.pcWrite     = pc_w;
    assign bus.ifidWrite   = ifid_w;
    assign bus.ifidFlush   = ifid_f;
    assign bus.idexWrite   = idex_w;
    assign bus.idexBubble  = idex_b;
    assign bus.exmemWrite  = exmem_w;
    assign bus.state       = state_q;
    assign bus.stallCycles = stall_q;
    assign bus.flushCount  = flush_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: two instances (LOAD_LATENCY 1 and 3,
// 4-bit counters) driven with identical inputs.
module tb_hazard_ctrl;
    localparam int unsigned CW = 4;

    // control bundle order: pcWrite ifidWrite ifidFlush idexWrite idexBubble exmemWrite
    localparam logic [5:0] NORM  = 6'b110101;
    localparam logic [5:0] STALL = 6'b000111;
    localparam logic [5:0] REDIR = 6'b111111;
    localparam logic [5:0] FRZ   = 6'b000000;
    localparam logic [5:0] RST   = 6'b001010;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CW)) b1 ();
    hazard_ctrl_if #(.CNT_W(CW)) b3 ();

    hazard_ctrl #(.LOAD_LATENCY(1), .CNT_W(CW)) dut1 (.clk(clk), .reset(reset), .bus(b1));
    hazard_ctrl #(.LOAD_LATENCY(3), .CNT_W(CW)) dut3 (.clk(clk), .reset(reset), .bus(b3));

    assign b3.rs_ID          = b1.rs_ID;
    assign b3.rt_ID          = b1.rt_ID;
    assign b3.usesRs_ID      = b1.usesRs_ID;
    assign b3.usesRt_ID      = b1.usesRt_ID;
    assign b3.MemRead_EX     = b1.MemRead_EX;
    assign b3.rt_EX          = b1.rt_EX;
    assign b3.branchTaken_EX = b1.branchTaken_EX;
    assign b3.Jump_EX        = b1.Jump_EX;
    assign b3.memBusy        = b1.memBusy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [5:0] ctl1();
        return {b1.pcWrite, b1.ifidWrite, b1.ifidFlush, b1.idexWrite, b1.idexBubble, b1.exmemWrite};
    endfunction

    function automatic logic [5:0] ctl3();
        return {b3.pcWrite, b3.ifidWrite, b3.ifidFlush, b3.idexWrite, b3.idexBubble, b3.exmemWrite};
    endfunction

    task automatic chk1(input string tag, input logic [5:0] c, input int unsigned st,
                        input int unsigned sc, input int unsigned fc);
        check({tag, " L1 ctl"},   32'(ctl1()), 32'(c));
        check({tag, " L1 state"}, 32'(b1.state), st);
        check({tag, " L1 stall"}, 32'(b1.stallCycles), sc);
        check({tag, " L1 flush"}, 32'(b1.flushCount), fc);
    endtask

    task automatic chk3(input string tag, input logic [5:0] c, input int unsigned st,
                        input int unsigned sc, input int unsigned fc);
        check({tag, " L3 ctl"},   32'(ctl3()), 32'(c));
        check({tag, " L3 state"}, 32'(b3.state), st);
        check({tag, " L3 stall"}, 32'(b3.stallCycles), sc);
        check({tag, " L3 flush"}, 32'(b3.flushCount), fc);
    endtask

    task automatic clr_in();
        b1.rs_ID = '0; b1.rt_ID = '0; b1.usesRs_ID = 1'b0; b1.usesRt_ID = 1'b0;
        b1.MemRead_EX = 1'b0; b1.rt_EX = '0; b1.branchTaken_EX = 1'b0;
        b1.Jump_EX = 1'b0; b1.memBusy = 1'b0;
    endtask

    // lw $5 in EX, add $x,$5,$7 in ID
    task automatic load_use();
        clr_in();
        b1.MemRead_EX = 1'b1; b1.rt_EX = 5'd5;
        b1.rs_ID = 5'd5; b1.usesRs_ID = 1'b1;
        b1.rt_ID = 5'd7; b1.usesRt_ID = 1'b1;
    endtask

    initial begin
        clr_in();

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            reset = 1'b1;
            b1.rs_ID = 5'($urandom); b1.rt_ID = 5'($urandom); b1.rt_EX = 5'($urandom);
            b1.usesRs_ID = 1'($urandom); b1.usesRt_ID = 1'($urandom);
            b1.MemRead_EX = 1'($urandom); b1.branchTaken_EX = 1'($urandom);
            b1.Jump_EX = 1'($urandom); b1.memBusy = 1'($urandom);
            #1;
            check("reset L1 ctl", 32'(ctl1()), 32'(RST));
            check("reset L3 ctl", 32'(ctl3()), 32'(RST));
        end
        @(negedge clk); reset = 1'b0; clr_in(); #1;
        chk1("post-reset", NORM, 0, 0, 0);
        chk3("post-reset", NORM, 0, 0, 0);

        // load-use: 1 bubble for L1, 3 for L3
        @(negedge clk); load_use(); #1;
        chk1("lu c0", STALL, 0, 0, 0); chk3("lu c0", STALL, 0, 0, 0);
        @(negedge clk); clr_in(); #1;
        chk1("lu c1", NORM, 0, 1, 0);  chk3("lu c1", STALL, 1, 1, 0);
        @(negedge clk); clr_in(); #1;
        chk1("lu c2", NORM, 0, 1, 0);  chk3("lu c2", STALL, 1, 2, 0);
        @(negedge clk); clr_in(); #1;
        chk1("lu c3", NORM, 0, 1, 0);  chk3("lu c3", NORM, 0, 3, 0);

        // redirect beats a simultaneous load-use
        @(negedge clk); load_use(); b1.branchTaken_EX = 1'b1; #1;
        chk1("br+lu", REDIR, 0, 1, 0); chk3("br+lu", REDIR, 0, 3, 0);
        @(negedge clk); clr_in(); #1;
        chk1("br after", NORM, 0, 1, 1); chk3("br after", NORM, 0, 3, 1);

        // freeze in the middle of the L3 stall (remaining=1)
        @(negedge clk); load_use(); #1;
        chk1("fz lu", STALL, 0, 1, 1); chk3("fz lu", STALL, 0, 3, 1);
        @(negedge clk); clr_in(); #1;
        chk1("fz ls", NORM, 0, 2, 1);  chk3("fz ls", STALL, 1, 4, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); clr_in(); b1.memBusy = 1'b1; #1;
            chk1("fz busy", FRZ, (k == 0) ? 0 : 3, 2 + k, 1);
            chk3("fz busy", FRZ, (k == 0) ? 1 : 3, 5 + k, 1);
        end
        @(negedge clk); clr_in(); #1;
        chk1("fz resume", NORM, 3, 6, 1); chk3("fz resume", STALL, 3, 9, 1);
        @(negedge clk); clr_in(); #1;
        chk1("fz done", NORM, 0, 6, 1);   chk3("fz done", NORM, 0, 10, 1);

        // redirect during memBusy is deferred
        @(negedge clk); clr_in(); b1.memBusy = 1'b1; b1.Jump_EX = 1'b1; #1;
        chk1("jmp busy", FRZ, 0, 6, 1);   chk3("jmp busy", FRZ, 0, 10, 1);
        @(negedge clk); clr_in(); b1.Jump_EX = 1'b1; #1;
        chk1("jmp go", REDIR, 3, 7, 1);   chk3("jmp go", REDIR, 3, 11, 1);
        @(negedge clk); clr_in(); #1;
        chk1("jmp after", NORM, 0, 7, 2); chk3("jmp after", NORM, 0, 11, 2);

        // $zero never forms a hazard; unused source never forms a hazard
        @(negedge clk); clr_in();
        b1.MemRead_EX = 1'b1; b1.usesRs_ID = 1'b1; b1.usesRt_ID = 1'b1; #1;
        chk1("zero", NORM, 0, 7, 2); chk3("zero", NORM, 0, 11, 2);
        @(negedge clk); clr_in();
        b1.MemRead_EX = 1'b1; b1.rt_EX = 5'd5; b1.usesRs_ID = 1'b1;
        b1.rt_ID = 5'd5; b1.usesRt_ID = 1'b0; #1;
        chk1("unused rt", NORM, 0, 7, 2); chk3("unused rt", NORM, 0, 11, 2);

        // 2^CW+5 freeze cycles saturate the stall counter
        for (int k = 0; k < (1 << CW) + 5; k++) begin
            @(negedge clk); clr_in(); b1.memBusy = 1'b1; #1;
            check("sat L1 ctl", 32'(ctl1()), 32'(FRZ));
            check("sat L3 ctl", 32'(ctl3()), 32'(FRZ));
        end
        @(negedge clk); clr_in(); b1.memBusy = 1'b1; #1;
        chk1("sat", FRZ, 3, 15, 2); chk3("sat", FRZ, 3, 15, 2);

        // reset during FREEZE
        @(negedge clk); reset = 1'b1; #1;
        check("rst fz L1 ctl", 32'(ctl1()), 32'(RST));
        check("rst fz L3 ctl", 32'(ctl3()), 32'(RST));
        @(negedge clk); reset = 1'b0; clr_in(); #1;
        chk1("rst fz after", NORM, 0, 0, 0); chk3("rst fz after", NORM, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
